// File: rtl/rp_8bit_asm_emit.sv
// Streaming AVR instruction encoder and program-memory loader for the rp_8bit core.
// Define RP_8BIT_ASM_ALIAS_EN to accept the LSL/ROL/TST/CLR aliases (ops 50-53).
module rp_8bit_asm_emit #(
    parameter int unsigned AW  = 16,
    parameter int unsigned ECW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           org_vld_i,
    input  logic [AW-1:0]  org_adr_i,
    input  logic           req_vld_i,
    output logic           req_rdy_o,
    input  logic [5:0]     req_op_i,
    input  logic [4:0]     req_rd_i,
    input  logic [4:0]     req_rr_i,
    input  logic [21:0]    req_k_i,
    input  logic [2:0]     req_b_i,
    output logic           mem_we_o,
    output logic [AW-1:0]  mem_adr_o,
    output logic [15:0]    mem_dat_o,
    output logic           err_o,
    output logic [ECW-1:0] err_cnt_o,
    output logic [AW-1:0]  wr_cnt_o
);

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_MOVW = 6'd1;
    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_ADC  = 6'd3;
    localparam logic [5:0] OP_SUB  = 6'd4;
    localparam logic [5:0] OP_SBC  = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_EOR  = 6'd8;
    localparam logic [5:0] OP_MOV  = 6'd9;
    localparam logic [5:0] OP_CP   = 6'd10;
    localparam logic [5:0] OP_CPC  = 6'd11;
    localparam logic [5:0] OP_CPSE = 6'd12;
    localparam logic [5:0] OP_MUL  = 6'd13;
    localparam logic [5:0] OP_CPI  = 6'd14;
    localparam logic [5:0] OP_SBCI = 6'd15;
    localparam logic [5:0] OP_SUBI = 6'd16;
    localparam logic [5:0] OP_ORI  = 6'd17;
    localparam logic [5:0] OP_ANDI = 6'd18;
    localparam logic [5:0] OP_LDI  = 6'd19;
    localparam logic [5:0] OP_COM  = 6'd20;
    localparam logic [5:0] OP_NEG  = 6'd21;
    localparam logic [5:0] OP_SWAP = 6'd22;
    localparam logic [5:0] OP_INC  = 6'd23;
    localparam logic [5:0] OP_DEC  = 6'd24;
    localparam logic [5:0] OP_ASR  = 6'd25;
    localparam logic [5:0] OP_LSR  = 6'd26;
    localparam logic [5:0] OP_ROR  = 6'd27;
    localparam logic [5:0] OP_PUSH = 6'd28;
    localparam logic [5:0] OP_POP  = 6'd29;
    localparam logic [5:0] OP_IN   = 6'd30;
    localparam logic [5:0] OP_OUT  = 6'd31;
    localparam logic [5:0] OP_CBI  = 6'd32;
    localparam logic [5:0] OP_SBI  = 6'd33;
    localparam logic [5:0] OP_ADIW = 6'd34;
    localparam logic [5:0] OP_SBIW = 6'd35;
    localparam logic [5:0] OP_BSET = 6'd36;
    localparam logic [5:0] OP_BCLR = 6'd37;
    localparam logic [5:0] OP_BLD  = 6'd38;
    localparam logic [5:0] OP_BST  = 6'd39;
    localparam logic [5:0] OP_RJMP = 6'd40;
    localparam logic [5:0] OP_RCAL = 6'd41;
    localparam logic [5:0] OP_BRBS = 6'd42;
    localparam logic [5:0] OP_BRBC = 6'd43;
    localparam logic [5:0] OP_JMP  = 6'd44;
    localparam logic [5:0] OP_CALL = 6'd45;
    localparam logic [5:0] OP_LDS  = 6'd46;
    localparam logic [5:0] OP_STS  = 6'd47;
    localparam logic [5:0] OP_RET  = 6'd48;
    localparam logic [5:0] OP_RETI = 6'd49;
`ifdef RP_8BIT_ASM_ALIAS_EN
    localparam logic [5:0] OP_LSL  = 6'd50;
    localparam logic [5:0] OP_ROL  = 6'd51;
    localparam logic [5:0] OP_TST  = 6'd52;
    localparam logic [5:0] OP_CLR  = 6'd53;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_EXT
    } state_e;

    // Two-register format: pppppp r dddd d rrrr
    function automatic logic [15:0] enc_rr(input logic [5:0] pfx, input logic [4:0] d,
                                           input logic [4:0] r);
        return {pfx, r[4], d, r[3:0]};
    endfunction

    // Register-immediate format, destination limited to r16..r31
    function automatic logic [15:0] enc_imm(input logic [3:0] pfx, input logic [4:0] d,
                                            input logic [7:0] kk);
        return {pfx, kk[7:4], d[3:0], kk[3:0]};
    endfunction

    // One-register format: ppppppp ddddd ssss
    function automatic logic [15:0] enc_1r(input logic [6:0] pfx, input logic [4:0] d,
                                           input logic [3:0] sfx);
        return {pfx, d, sfx};
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [15:0]     ext_q, ext_d;
    logic            rdy_q, rdy_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_adr_q, mem_adr_d;
    logic [15:0]     mem_dat_q, mem_dat_d;
    logic            err_q, err_d;
    logic [ECW-1:0]  err_cnt_q, err_cnt_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;

    logic            dec_bad;
    logic            dec_ext;
    logic [15:0]     dec_w0;
    logic            acc;

    // Operand range predicates; relative offsets are two's complement in req_k_i
    logic k_gt63, k_gt31, k_gtffff, k_rel12_bad, k_rel7_bad, rd_lo_bad, adiw_rd_bad;
    assign k_gt63      = |req_k_i[21:6];
    assign k_gt31      = |req_k_i[21:5];
    assign k_gtffff    = |req_k_i[21:16];
    assign k_rel12_bad = !((&req_k_i[21:11]) || !(|req_k_i[21:11]));
    assign k_rel7_bad  = !((&req_k_i[21:6]) || !(|req_k_i[21:6]));
    assign rd_lo_bad   = !req_rd_i[4];
    assign adiw_rd_bad = (req_rd_i[4:3] != 2'b11) || req_rd_i[0];

    // Instruction decode: first opcode word, range-check result, 32-bit flag
    always_comb begin
        dec_bad = 1'b0;
        dec_ext = 1'b0;
        dec_w0  = 16'h0000;
        case (req_op_i)
            OP_NOP:  dec_w0 = 16'h0000;
            OP_MOVW: begin
                dec_w0  = {8'h01, req_rd_i[4:1], req_rr_i[4:1]};
                dec_bad = req_rd_i[0] || req_rr_i[0];
            end
            OP_ADD:  dec_w0 = enc_rr(6'b000011, req_rd_i, req_rr_i);
            OP_ADC:  dec_w0 = enc_rr(6'b000111, req_rd_i, req_rr_i);
            OP_SUB:  dec_w0 = enc_rr(6'b000110, req_rd_i, req_rr_i);
            OP_SBC:  dec_w0 = enc_rr(6'b000010, req_rd_i, req_rr_i);
            OP_AND:  dec_w0 = enc_rr(6'b001000, req_rd_i, req_rr_i);
            OP_OR:   dec_w0 = enc_rr(6'b001010, req_rd_i, req_rr_i);
            OP_EOR:  dec_w0 = enc_rr(6'b001001, req_rd_i, req_rr_i);
            OP_MOV:  dec_w0 = enc_rr(6'b001011, req_rd_i, req_rr_i);
            OP_CP:   dec_w0 = enc_rr(6'b000101, req_rd_i, req_rr_i);
            OP_CPC:  dec_w0 = enc_rr(6'b000001, req_rd_i, req_rr_i);
            OP_CPSE: dec_w0 = enc_rr(6'b000100, req_rd_i, req_rr_i);
            OP_MUL:  dec_w0 = enc_rr(6'b100111, req_rd_i, req_rr_i);
            OP_CPI:  begin dec_w0 = enc_imm(4'h3, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_SBCI: begin dec_w0 = enc_imm(4'h4, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_SUBI: begin dec_w0 = enc_imm(4'h5, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_ORI:  begin dec_w0 = enc_imm(4'h6, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_ANDI: begin dec_w0 = enc_imm(4'h7, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_LDI:  begin dec_w0 = enc_imm(4'hE, req_rd_i, req_k_i[7:0]); dec_bad = rd_lo_bad; end
            OP_COM:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h0);
            OP_NEG:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h1);
            OP_SWAP: dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h2);
            OP_INC:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h3);
            OP_DEC:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'hA);
            OP_ASR:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h5);
            OP_LSR:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h6);
            OP_ROR:  dec_w0 = enc_1r(7'b1001010, req_rd_i, 4'h7);
            OP_PUSH: dec_w0 = enc_1r(7'b1001001, req_rr_i, 4'hF);
            OP_POP:  dec_w0 = enc_1r(7'b1001000, req_rd_i, 4'hF);
            OP_IN:   begin dec_w0 = {5'b10110, req_k_i[5:4], req_rd_i, req_k_i[3:0]}; dec_bad = k_gt63; end
            OP_OUT:  begin dec_w0 = {5'b10111, req_k_i[5:4], req_rr_i, req_k_i[3:0]}; dec_bad = k_gt63; end
            OP_CBI:  begin dec_w0 = {8'h98, req_k_i[4:0], req_b_i}; dec_bad = k_gt31; end
            OP_SBI:  begin dec_w0 = {8'h9A, req_k_i[4:0], req_b_i}; dec_bad = k_gt31; end
            OP_ADIW: begin
                dec_w0  = {8'h96, req_k_i[5:4], req_rd_i[2:1], req_k_i[3:0]};
                dec_bad = adiw_rd_bad || k_gt63;
            end
            OP_SBIW: begin
                dec_w0  = {8'h97, req_k_i[5:4], req_rd_i[2:1], req_k_i[3:0]};
                dec_bad = adiw_rd_bad || k_gt63;
            end
            OP_BSET: dec_w0 = {9'b100101000, req_b_i, 4'b1000};
            OP_BCLR: dec_w0 = {9'b100101001, req_b_i, 4'b1000};
            OP_BLD:  dec_w0 = {7'b1111100, req_rd_i, 1'b0, req_b_i};
            OP_BST:  dec_w0 = {7'b1111101, req_rd_i, 1'b0, req_b_i};
            OP_RJMP: begin dec_w0 = {4'hC, req_k_i[11:0]}; dec_bad = k_rel12_bad; end
            OP_RCAL: begin dec_w0 = {4'hD, req_k_i[11:0]}; dec_bad = k_rel12_bad; end
            OP_BRBS: begin dec_w0 = {6'b111100, req_k_i[6:0], req_b_i}; dec_bad = k_rel7_bad; end
            OP_BRBC: begin dec_w0 = {6'b111101, req_k_i[6:0], req_b_i}; dec_bad = k_rel7_bad; end
            OP_JMP:  begin dec_w0 = {7'b1001010, req_k_i[21:17], 3'b110, req_k_i[16]}; dec_ext = 1'b1; end
            OP_CALL: begin dec_w0 = {7'b1001010, req_k_i[21:17], 3'b111, req_k_i[16]}; dec_ext = 1'b1; end
            OP_LDS:  begin
                dec_w0  = enc_1r(7'b1001000, req_rd_i, 4'h0);
                dec_ext = 1'b1;
                dec_bad = k_gtffff;
            end
            OP_STS:  begin
                dec_w0  = enc_1r(7'b1001001, req_rr_i, 4'h0);
                dec_ext = 1'b1;
                dec_bad = k_gtffff;
            end
            OP_RET:  dec_w0 = 16'h9508;
            OP_RETI: dec_w0 = 16'h9518;
`ifdef RP_8BIT_ASM_ALIAS_EN
            OP_LSL:  dec_w0 = enc_rr(6'b000011, req_rd_i, req_rd_i);
            OP_ROL:  dec_w0 = enc_rr(6'b000111, req_rd_i, req_rd_i);
            OP_TST:  dec_w0 = enc_rr(6'b001000, req_rd_i, req_rd_i);
            OP_CLR:  dec_w0 = enc_rr(6'b001001, req_rd_i, req_rd_i);
`endif
            default: dec_bad = 1'b1;
        endcase
    end

    // Origin load has priority over a request in the same cycle
    assign req_rdy_o = rdy_q && !org_vld_i;
    assign acc       = req_vld_i && req_rdy_o;

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        ext_d     = ext_q;
        mem_we_d  = 1'b0;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (org_vld_i) begin
                    adr_d = org_adr_i;
                end else if (acc) begin
                    if (dec_bad) begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ECW{1'b1}}) err_cnt_d = err_cnt_q + ECW'(1);
                    end else begin
                        mem_we_d  = 1'b1;
                        mem_adr_d = adr_q;
                        mem_dat_d = dec_w0;
                        adr_d     = adr_q + AW'(1);
                        wr_cnt_d  = wr_cnt_q + AW'(1);
                        if (dec_ext) begin
                            ext_d   = req_k_i[15:0];
                            state_d = ST_EXT;
                        end
                    end
                end
            end
            ST_EXT: begin
                mem_we_d  = 1'b1;
                mem_adr_d = adr_q;
                mem_dat_d = ext_q;
                adr_d     = adr_q + AW'(1);
                wr_cnt_d  = wr_cnt_q + AW'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            ext_q     <= '0;
            rdy_q     <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            ext_q     <= ext_d;
            rdy_q     <= rdy_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign mem_we_o  = mem_we_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_dat_o = mem_dat_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_rp_8bit_asm_emit.sv
// Self-checking bench for rp_8bit_asm_emit: directed test-plan cases plus randomized requests
// compared every cycle against a transaction-level encoding model.
module tb_rp_8bit_asm_emit;

`ifdef RP_8BIT_ASM_ALIAS_EN
    localparam bit ALIAS = 1'b1;
`else
    localparam bit ALIAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        org_vld_i = 1'b0;
    logic [15:0] org_adr_i = '0;
    logic        req_vld_i = 1'b0;
    logic        req_rdy_o;
    logic [5:0]  req_op_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic [4:0]  req_rr_i = '0;
    logic [21:0] req_k_i = '0;
    logic [2:0]  req_b_i = '0;
    logic        mem_we_o;
    logic [15:0] mem_adr_o;
    logic [15:0] mem_dat_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;
    logic [15:0] wr_cnt_o;

    rp_8bit_asm_emit #(.AW(16), .ECW(8)) dut (
        .clk(clk), .rst_n(rst_n), .org_vld_i(org_vld_i), .org_adr_i(org_adr_i),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_rr_i(req_rr_i), .req_k_i(req_k_i), .req_b_i(req_b_i),
        .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o), .wr_cnt_o(wr_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     is_err;
        int     adr;
        int     dat;
        longint due;
    } ev_t;

    ev_t    evq[$];
    int     checks = 0;
    int     fails = 0;
    longint cyc = 0;
    bit     m_ready = 0;
    bit     m_ext = 0;
    int     m_adr = 0;
    bit     last_acc = 0;
    int     m_wr = 0;
    int     m_ec = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Encoding model straight from the AVR opcode tables
    function automatic void m_enc(input int op_in, input int d, input int r_in, input int k,
                                  input int b, output bit bad, output bit ext,
                                  output int w0, output int w1);
        int rr_base[14] = '{0, 0, 'h0C00, 'h1C00, 'h1800, 'h0800, 'h2000, 'h2800, 'h2400,
                            'h2C00, 'h1400, 'h0400, 'h1000, 'h9C00};
        int imm_base[6] = '{'h3000, 'h4000, 'h5000, 'h6000, 'h7000, 'hE000};
        int one_sfx[8]  = '{0, 1, 2, 3, 10, 5, 6, 7};
        int alias_op[4] = '{2, 3, 6, 8};
        int op = op_in;
        int r = r_in;
        int ks = (k >= 'h200000) ? k - 'h400000 : k;
        int kk = k % 256;
        bad = 0; ext = 0; w0 = 0; w1 = 0;
        if (ALIAS && op >= 50 && op <= 53) begin
            op = alias_op[op-50];
            r  = d;
        end
        if (op == 0) w0 = 0;
        else if (op == 1) begin
            bad = (d % 2 != 0) || (r % 2 != 0);
            w0 = 'h0100 + (d / 2) * 16 + r / 2;
        end else if (op >= 2 && op <= 13) w0 = rr_base[op] + (r / 16) * 512 + d * 16 + r % 16;
        else if (op >= 14 && op <= 19) begin
            bad = d < 16;
            w0 = imm_base[op-14] + (kk / 16) * 256 + (d % 16) * 16 + kk % 16;
        end else if (op >= 20 && op <= 27) w0 = 'h9400 + d * 16 + one_sfx[op-20];
        else if (op == 28) w0 = 'h920F + r * 16;
        else if (op == 29) w0 = 'h900F + d * 16;
        else if (op == 30 || op == 31) begin
            bad = k > 63;
            w0 = ((op == 30) ? 'hB000 : 'hB800) + ((k % 64) / 16) * 512 +
                 ((op == 30) ? d : r) * 16 + k % 16;
        end else if (op == 32 || op == 33) begin
            bad = k > 31;
            w0 = ((op == 32) ? 'h9800 : 'h9A00) + (k % 32) * 8 + b;
        end else if (op == 34 || op == 35) begin
            bad = !(d == 24 || d == 26 || d == 28 || d == 30) || k > 63;
            w0 = ((op == 34) ? 'h9600 : 'h9700) + ((k % 64) / 16) * 64 + ((d % 8) / 2) * 16 + k % 16;
        end else if (op == 36) w0 = 'h9408 + b * 16;
        else if (op == 37) w0 = 'h9488 + b * 16;
        else if (op == 38) w0 = 'hF800 + d * 16 + b;
        else if (op == 39) w0 = 'hFA00 + d * 16 + b;
        else if (op == 40 || op == 41) begin
            bad = ks < -2048 || ks > 2047;
            w0 = ((op == 40) ? 'hC000 : 'hD000) + (ks & 'hFFF);
        end else if (op == 42 || op == 43) begin
            bad = ks < -64 || ks > 63;
            w0 = ((op == 42) ? 'hF000 : 'hF400) + (ks & 127) * 8 + b;
        end else if (op == 44 || op == 45) begin
            ext = 1;
            w0 = ((op == 44) ? 'h940C : 'h940E) + (k / 'h20000) * 16 + (k / 'h10000) % 2;
            w1 = k % 'h10000;
        end else if (op == 46 || op == 47) begin
            bad = k > 'hFFFF;
            ext = 1;
            w0 = (op == 46) ? 'h9000 + d * 16 : 'h9200 + r * 16;
            w1 = k % 'h10000;
        end else if (op == 48) w0 = 'h9508;
        else if (op == 49) w0 = 'h9518;
        else bad = 1;
    endfunction

    // Request/origin monitor: decides acceptance and queues expected output events
    initial begin
        bit bad, ext;
        int w0, w1;
        forever begin
            @(posedge clk);
            cyc++;
            last_acc = 0;
            if (!rst_n) begin
                m_ready = 0; m_ext = 0; m_adr = 0;
            end else begin
                if (m_ext) m_ext = 0;
                else if (org_vld_i) m_adr = int'(org_adr_i);
                else if (m_ready && req_vld_i) begin
                    last_acc = 1;
                    m_enc(int'(req_op_i), int'(req_rd_i), int'(req_rr_i), int'(req_k_i),
                          int'(req_b_i), bad, ext, w0, w1);
                    if (bad) evq.push_back('{1'b1, 0, 0, cyc});
                    else begin
                        evq.push_back('{1'b0, m_adr, w0, cyc});
                        m_adr = (m_adr + 1) % 65536;
                        if (ext) begin
                            evq.push_back('{1'b0, m_adr, w1, cyc + 1});
                            m_adr = (m_adr + 1) % 65536;
                            m_ext = 1;
                        end
                    end
                end
                m_ready = !m_ext;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                evq.delete(); m_wr = 0; m_ec = 0;
                chk("rst_rdy", req_rdy_o, 0);
                chk("rst_we", mem_we_o, 0);
                chk("rst_adr", mem_adr_o, 0);
                chk("rst_dat", mem_dat_o, 0);
                chk("rst_err", err_o, 0);
                chk("rst_errcnt", err_cnt_o, 0);
                chk("rst_wrcnt", wr_cnt_o, 0);
            end else begin
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    e = evq.pop_front();
                    chk("cyc_we", mem_we_o, !e.is_err);
                    chk("cyc_err", err_o, e.is_err);
                    if (e.is_err) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    else begin
                        chk("cyc_adr", mem_adr_o, e.adr);
                        chk("cyc_dat", mem_dat_o, e.dat);
                        m_wr = (m_wr + 1) % 65536;
                    end
                end else begin
                    chk("idle_we", mem_we_o, 0);
                    chk("idle_err", err_o, 0);
                end
                chk("cyc_errcnt", err_cnt_o, m_ec);
                chk("cyc_wrcnt", wr_cnt_o, m_wr);
                chk("cyc_rdy", req_rdy_o, m_ready && !org_vld_i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        req_vld_i = 0;
        repeat (n) step();
    endtask

    task automatic org(input int a);
        org_vld_i = 1;
        org_adr_i = 16'(a);
        step();
        org_vld_i = 0;
    endtask

    // Present one request and hold it until accepted; returns cycles waited
    task automatic send(input int op, input int rd, input int rr, input int k, input int b,
                        input bit org_en, input int org_a, output int n);
        req_vld_i = 1;
        req_op_i = 6'(op); req_rd_i = 5'(rd); req_rr_i = 5'(rr);
        req_k_i = 22'(k); req_b_i = 3'(b);
        org_vld_i = org_en; org_adr_i = 16'(org_a);
        n = 0;
        do begin
            step();
            org_vld_i = 0;
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("accept_timeout", 0, 1);
        req_vld_i = 0;
    endtask

    int bnd[16] = '{0, 31, 32, 63, 64, 255, 2047, 2048, 'h3FF800, 'h3FF7FF,
                    'h3FFFC0, 'h3FFFBF, 'hFFFF, 'h10000, 'h3FFFFF, 'h1FFFFF};

    initial begin
        bit bad, ext;
        int w0, w1, n, op, k;

        // Pin the model against hand-encoded opcodes
        m_enc(2, 1, 2, 0, 0, bad, ext, w0, w1);        chk("pin_add", w0, 'h0C12);
        m_enc(19, 16, 0, 'hFF, 0, bad, ext, w0, w1);   chk("pin_ldi", w0, 'hEF0F);
        m_enc(40, 0, 0, 'h3FFFFF, 0, bad, ext, w0, w1); chk("pin_rjmp", w0, 'hCFFF);
        m_enc(44, 0, 0, 'h100, 0, bad, ext, w0, w1);   chk("pin_jmp", w0 * 65536 + w1, 'h940C0100);
        m_enc(31, 0, 0, 'h3F, 0, bad, ext, w0, w1);    chk("pin_out", w0, 'hBE0F);
        m_enc(35, 28, 0, 1, 0, bad, ext, w0, w1);      chk("pin_sbiw", w0, 'h9721);
        m_enc(43, 0, 0, 'h3FFFFE, 1, bad, ext, w0, w1); chk("pin_brbc", w0, 'hF7F1);
        m_enc(34, 25, 0, 1, 0, bad, ext, w0, w1);      chk("pin_adiw_bad", bad, 1);

        repeat (3) step();
        chk("rst_rdy_low", req_rdy_o, 0);
        rst_n = 1;
        step();
        chk("rdy_after_rst", req_rdy_o, 1);

        org('h0010);
        send(2, 1, 2, 0, 0, 0, 0, n);
        chk("add_we", mem_we_o, 1); chk("add_adr", mem_adr_o, 'h10); chk("add_dat", mem_dat_o, 'h0C12);

        send(19, 16, 0, 'hFF, 0, 0, 0, n);
        chk("ldi_adr", mem_adr_o, 'h11); chk("ldi_dat", mem_dat_o, 'hEF0F);
        send(40, 0, 0, 'h3FFFFF, 0, 0, 0, n);
        chk("rjmp_b2b", n, 1); chk("rjmp_adr", mem_adr_o, 'h12); chk("rjmp_dat", mem_dat_o, 'hCFFF);

        send(44, 0, 0, 'h100, 0, 0, 0, n);
        chk("jmp_w0", mem_dat_o, 'h940C); chk("jmp_a0", mem_adr_o, 'h13); chk("jmp_rdy", req_rdy_o, 0);
        step();
        chk("jmp_we1", mem_we_o, 1); chk("jmp_w1", mem_dat_o, 'h0100);
        chk("jmp_a1", mem_adr_o, 'h14); chk("jmp_wrcnt", wr_cnt_o, 5);

        send(19, 5, 0, 1, 0, 0, 0, n);
        chk("ldi_r5_err", err_o, 1); chk("ldi_r5_we", mem_we_o, 0);
        send(34, 25, 0, 1, 0, 0, 0, n);
        chk("adiw_err", err_o, 1); chk("adiw_we", mem_we_o, 0); chk("errcnt2", err_cnt_o, 2);
        send(2, 3, 4, 0, 0, 0, 0, n);
        chk("after_err_adr", mem_adr_o, 'h15);

        org('hFFFF);
        send(45, 0, 0, 'h2ABCD, 0, 0, 0, n);
        chk("wrap_a0", mem_adr_o, 'hFFFF);
        step();
        chk("wrap_a1", mem_adr_o, 0); chk("wrap_w1", mem_dat_o, 'hABCD);

        org('h0020);
        send(44, 0, 0, 'h1234, 0, 0, 0, n);
        chk("ext_rst_w0", mem_we_o, 1);
        rst_n = 0;
        #1;
        chk("ext_rst_we", mem_we_o, 0); chk("ext_rst_adr", mem_adr_o, 0);
        chk("ext_rst_dat", mem_dat_o, 0); chk("ext_rst_wrcnt", wr_cnt_o, 0);
        chk("ext_rst_errcnt", err_cnt_o, 0);
        #1;
        repeat (2) step();
        rst_n = 1;
        step();

        send(53, 3, 9, 0, 0, 0, 0, n);
        if (ALIAS) begin
            chk("clr_we", mem_we_o, 1); chk("clr_dat", mem_dat_o, 'h2433);
        end else begin
            chk("clr_err", err_o, 1); chk("clr_we", mem_we_o, 0);
        end

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(54, 63)) : int'($urandom_range(0, 53));
            case ($urandom_range(0, 3))
                0: k = int'($urandom & 32'h003F_FFFF);
                1: k = bnd[$urandom_range(0, 15)];
                2: k = int'($urandom_range(0, 127));
                default: k = 'h400000 - int'($urandom_range(1, 130));
            endcase
            send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), k,
                 int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 65535)), n);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);
        chk("queue_drained", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
